csr_trap_ctrl: RTL and testbench

//  Core-local trap sequencer sitting between ex/id and csr_reg. Detects ecall/ebreak/mret and external

---
 rtl/csr_trap_ctrl_pkg.sv | 49 ++++
 rtl/csr_trap_ctrl_int_prio_enc.sv | 29 ++
 rtl/csr_trap_ctrl.sv | 178 +++++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_trap_ctrl_pkg.sv
// csr_trap_ctrl_pkg
//   Shared definitions for the trap sequencer: CSR addresses, system
//   instruction encodings, trap cause codes, mstatus bit positions and
//   the FSM state encoding.
//   No ports; imported by csr_trap_ctrl and its sub-module.
package csr_trap_ctrl_pkg;

  // CSR addresses (12-bit CSR space)
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // System instruction encodings
  localparam logic [31:0] ENC_ECALL  = 32'h0000_0073;
  localparam logic [31:0] ENC_EBREAK = 32'h0010_0073;
  localparam logic [31:0] ENC_MRET   = 32'h3020_0073;

  // Cause codes; external interrupts add the request index to the base
  localparam logic [31:0] CAUSE_ECALL    = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK   = 32'd3;
  localparam logic [31:0] CAUSE_INT_BASE = 32'h8000_0010;

  // mstatus bit positions
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_DIV  = 3'd1;
  localparam logic [2:0] ST_W_MEPC    = 3'd2;
  localparam logic [2:0] ST_W_MSTATUS = 3'd3;
  localparam logic [2:0] ST_W_MCAUSE  = 3'd4;
  localparam logic [2:0] ST_ASSERT    = 3'd5;
  localparam logic [2:0] ST_M_MSTATUS = 3'd6;
  localparam logic [2:0] ST_M_ASSERT  = 3'd7;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    WAIT_DIV  = ST_WAIT_DIV,
    W_MEPC    = ST_W_MEPC,
    W_MSTATUS = ST_W_MSTATUS,
    W_MCAUSE  = ST_W_MCAUSE,
    ASSERT    = ST_ASSERT,
    M_MSTATUS = ST_M_MSTATUS,
    M_ASSERT  = ST_M_ASSERT
  } trap_state_t;

endpackage

// File: rtl/csr_trap_ctrl_int_prio_enc.sv
// csr_trap_ctrl_int_prio_enc
//   Combinational priority encoder for the external interrupt lines.
//   The lowest set bit wins (bit 0 is the highest priority request).
// Ports:
//   int_flag   in   INT_W   interrupt request levels
//   int_idx    out  IDX_W   index of the lowest set request (0 when none)
//   int_valid  out  1       at least one request is set
module csr_trap_ctrl_int_prio_enc #(
  parameter int INT_W = 8,
  parameter int IDX_W = 3
) (
  input  logic [INT_W-1:0] int_flag,
  output logic [IDX_W-1:0] int_idx,
  output logic             int_valid
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    int_idx   = '0;
    int_valid = 1'b0;
    for (int i = INT_W - 1; i >= 0; i--) begin
      if (int_flag[i]) begin
        int_idx   = IDX_W'(i);
        int_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl
//   Core-local trap sequencer. Detects ecall/ebreak/mret in ex and enabled
//   external interrupts, holds the pipeline, writes mepc/mstatus/mcause via
//   the csr_reg clint-side port, then redirects the PC to mtvec (trap) or
//   mepc (mret).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   int_flag_i        INT_W level interrupt requests, bit 0 highest priority
//   inst_i            instruction in ex;  inst_addr_i its address
//   jump_flag_i       ex redirects the PC this cycle; jump_addr_i its target
//   div_started_i     multicycle divide in flight
//   global_int_en_i   mstatus.MIE
//   csr_mtvec_i, csr_mepc_i, csr_mstatus_i   current CSR values
//   we_o, waddr_o, data_o                    CSR write port
//   hold_flag_o                              pipeline stall request
//   int_assert_o, int_addr_o                 one-cycle PC redirect
module csr_trap_ctrl
  import csr_trap_ctrl_pkg::*;
#(
  parameter int              INT_W       = 8,
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] INST_ECALL  = XLEN'(ENC_ECALL),
  parameter logic [XLEN-1:0] INST_EBREAK = XLEN'(ENC_EBREAK),
  parameter logic [XLEN-1:0] INST_MRET   = XLEN'(ENC_MRET)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INT_W-1:0] int_flag_i,
  input  logic [XLEN-1:0]  inst_i,
  input  logic [XLEN-1:0]  inst_addr_i,
  input  logic             jump_flag_i,
  input  logic [XLEN-1:0]  jump_addr_i,
  input  logic             div_started_i,
  input  logic             global_int_en_i,
  input  logic [XLEN-1:0]  csr_mtvec_i,
  input  logic [XLEN-1:0]  csr_mepc_i,
  input  logic [XLEN-1:0]  csr_mstatus_i,
  output logic             we_o,
  output logic [XLEN-1:0]  waddr_o,
  output logic [XLEN-1:0]  data_o,
  output logic             hold_flag_o,
  output logic             int_assert_o,
  output logic [XLEN-1:0]  int_addr_o
);

  localparam int IDX_W = (INT_W > 1) ? $clog2(INT_W) : 1;

  trap_state_t     state;
  trap_state_t     state_next;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] epc_q;
  logic [IDX_W-1:0] int_idx;
  logic            int_valid;
  logic            is_ecall;
  logic            is_ebreak;
  logic            sync_det;
  logic            mret_det;
  logic            async_det;
  logic            trap_det;

  csr_trap_ctrl_int_prio_enc #(
    .INT_W (INT_W),
    .IDX_W (IDX_W)
  ) u_int_prio_enc (
    .int_flag  (int_flag_i),
    .int_idx   (int_idx),
    .int_valid (int_valid)
  );

  // Detection priority: synchronous trap, then mret, then enabled interrupt.
  // Interrupts are not latched, so a request that drops before IDLE is lost.
  assign is_ecall  = (inst_i == INST_ECALL);
  assign is_ebreak = (inst_i == INST_EBREAK);
  assign sync_det  = is_ecall || is_ebreak;
  assign mret_det  = !sync_det && (inst_i == INST_MRET);
  assign async_det = !sync_det && !mret_det && int_valid && global_int_en_i;
  assign trap_det  = sync_det || async_det;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Cause and return address are frozen at detection; an interrupt that has
  // to wait for the divider still returns to the instruction seen at detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      cause_q <= '0;
      epc_q   <= '0;
    end else if (state == IDLE && trap_det) begin
      if (is_ecall) begin
        cause_q <= XLEN'(CAUSE_ECALL);
        epc_q   <= inst_addr_i;
      end else if (is_ebreak) begin
        cause_q <= XLEN'(CAUSE_EBREAK);
        epc_q   <= inst_addr_i;
      end else begin
        cause_q <= XLEN'(CAUSE_INT_BASE) + XLEN'(int_idx);
        epc_q   <= jump_flag_i ? jump_addr_i : inst_addr_i;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (sync_det) begin
          state_next = W_MEPC;
        end else if (mret_det) begin
          state_next = M_MSTATUS;
        end else if (async_det) begin
          state_next = div_started_i ? WAIT_DIV : W_MEPC;
        end
      end
      WAIT_DIV:  state_next = div_started_i ? WAIT_DIV : W_MEPC;
      W_MEPC:    state_next = W_MSTATUS;
      W_MSTATUS: state_next = W_MCAUSE;
      W_MCAUSE:  state_next = ASSERT;
      ASSERT:    state_next = IDLE;
      M_MSTATUS: state_next = M_ASSERT;
      M_ASSERT:  state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Output decode: one CSR write per write state, redirect in the assert
  // states; address/data buses are zero whenever their strobe is low.
  always_comb begin
    we_o         = 1'b0;
    waddr_o      = '0;
    data_o       = '0;
    int_assert_o = 1'b0;
    int_addr_o   = '0;
    hold_flag_o  = (state != IDLE) || trap_det || mret_det;
    case (state)
      W_MEPC: begin
        we_o    = 1'b1;
        waddr_o = XLEN'(CSR_MEPC);
        data_o  = epc_q;
      end
      W_MSTATUS: begin
        we_o                 = 1'b1;
        waddr_o              = XLEN'(CSR_MSTATUS);
        data_o               = csr_mstatus_i;
        data_o[MSTATUS_MPIE] = csr_mstatus_i[MSTATUS_MIE];
        data_o[MSTATUS_MIE]  = 1'b0;
      end
      W_MCAUSE: begin
        we_o    = 1'b1;
        waddr_o = XLEN'(CSR_MCAUSE);
        data_o  = cause_q;
      end
      ASSERT: begin
        int_assert_o = 1'b1;
        int_addr_o   = csr_mtvec_i;
      end
      M_MSTATUS: begin
        we_o                 = 1'b1;
        waddr_o              = XLEN'(CSR_MSTATUS);
        data_o               = csr_mstatus_i;
        data_o[MSTATUS_MIE]  = csr_mstatus_i[MSTATUS_MPIE];
        data_o[MSTATUS_MPIE] = 1'b1;
      end
      M_ASSERT: begin
        int_assert_o = 1'b1;
        int_addr_o   = csr_mepc_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb_csr_trap_ctrl
//   Self-checking bench for csr_trap_ctrl. Each scenario presents one
//   detection cycle; a transaction-level model turns it into the list of
//   cycles the sequencer should produce (hold, CSR writes, redirect),
//   which is then compared cycle by cycle while the remaining inputs are
//   scrambled to show they are ignored mid-sequence.
module tb_csr_trap_ctrl;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [7:0]  int_flag_i;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        div_started_i;
  logic        global_int_en_i;
  logic [31:0] csr_mtvec_i;
  logic [31:0] csr_mepc_i;
  logic [31:0] csr_mstatus_i;
  logic        we_o;
  logic [31:0] waddr_o;
  logic [31:0] data_o;
  logic        hold_flag_o;
  logic        int_assert_o;
  logic [31:0] int_addr_o;

  int vecCount = 0;
  int errCount = 0;

  bit          randomCsr = 0;
  logic [31:0] msBase    = 32'h0;
  logic [31:0] mtvecBase = 32'h0;
  logic [31:0] mepcBase  = 32'h0;

  // dataKind: 0 fixed, 1 trap mstatus, 2 mret mstatus
  // addrKind: 1 mtvec, 2 mepc
  typedef struct {
    bit          hold;
    bit          we;
    logic [31:0] waddr;
    int          dataKind;
    logic [31:0] dataVal;
    bit          asrt;
    int          addrKind;
  } expCycle_t;

  expCycle_t expQ[$];

  csr_trap_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .int_flag_i      (int_flag_i),
    .inst_i          (inst_i),
    .inst_addr_i     (inst_addr_i),
    .jump_flag_i     (jump_flag_i),
    .jump_addr_i     (jump_addr_i),
    .div_started_i   (div_started_i),
    .global_int_en_i (global_int_en_i),
    .csr_mtvec_i     (csr_mtvec_i),
    .csr_mepc_i      (csr_mepc_i),
    .csr_mstatus_i   (csr_mstatus_i),
    .we_o            (we_o),
    .waddr_o         (waddr_o),
    .data_o          (data_o),
    .hold_flag_o     (hold_flag_o),
    .int_assert_o    (int_assert_o),
    .int_addr_o      (int_addr_o)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] trapMstatus(input logic [31:0] ms);
    logic [31:0] mie;
    mie = (ms >> 3) & 32'h1;
    return (ms & ~32'h88) | (mie << 7);
  endfunction

  function automatic logic [31:0] mretMstatus(input logic [31:0] ms);
    logic [31:0] mpie;
    mpie = (ms >> 7) & 32'h1;
    return (ms & ~32'h88) | (mpie << 3) | 32'h80;
  endfunction

  function automatic expCycle_t mkCycle(input bit hold, input bit we, input logic [31:0] wa,
                                        input int dk, input logic [31:0] dv, input bit a, input int ak);
    expCycle_t e;
    e.hold = hold; e.we = we; e.waddr = wa; e.dataKind = dk;
    e.dataVal = dv; e.asrt = a; e.addrKind = ak;
    return e;
  endfunction

  task automatic driveCsr();
    if (randomCsr) begin
      csr_mstatus_i = $urandom;
      csr_mtvec_i   = $urandom;
      csr_mepc_i    = $urandom;
    end else begin
      csr_mstatus_i = msBase;
      csr_mtvec_i   = mtvecBase;
      csr_mepc_i    = mepcBase;
    end
  endtask

  task automatic driveQuiet();
    inst_i = NOP; inst_addr_i = 32'h0; int_flag_i = 8'h0; jump_flag_i = 1'b0;
    jump_addr_i = 32'h0; div_started_i = 1'b0; global_int_en_i = 1'b0;
    driveCsr();
  endtask

  // Mid-sequence inputs, including system instructions and interrupts
  task automatic driveNoise();
    case ($urandom_range(0, 3))
      0:       inst_i = ECALL;
      1:       inst_i = MRET;
      2:       inst_i = EBREAK;
      default: inst_i = $urandom;
    endcase
    inst_addr_i     = $urandom;
    int_flag_i      = 8'($urandom);
    jump_flag_i     = 1'($urandom);
    jump_addr_i     = $urandom;
    global_int_en_i = 1'($urandom);
    driveCsr();
  endtask

  // Compare one cycle against its model entry (called at negedge)
  task automatic checkCycle(input expCycle_t e, input string tag);
    logic [31:0] expData;
    logic [31:0] expAddr;
    case (e.dataKind)
      1:       expData = trapMstatus(csr_mstatus_i);
      2:       expData = mretMstatus(csr_mstatus_i);
      default: expData = e.dataVal;
    endcase
    expAddr = (e.addrKind == 2) ? csr_mepc_i : csr_mtvec_i;
    checkOutput({tag, ".hold"}, hold_flag_o, e.hold);
    checkOutput({tag, ".we"}, we_o, e.we);
    if (e.we) begin
      checkOutput({tag, ".waddr"}, waddr_o & 32'hfff, e.waddr);
      checkOutput({tag, ".data"}, data_o, expData);
    end
    checkOutput({tag, ".assert"}, int_assert_o, e.asrt);
    if (e.asrt) checkOutput({tag, ".int_addr"}, int_addr_o, expAddr);
  endtask

  // One scenario: model the expected cycle list from the detect-cycle
  // inputs, then drive and check it. Entered and left just after posedge.
  task automatic applyStimulus(input logic [31:0] inst, input logic [31:0] addr,
                               input logic [7:0] intFlag, input bit mie, input bit jf,
                               input logic [31:0] ja, input int divWait, input string tag);
    bit          isSync;
    bit          isMret;
    bit          isAsync;
    logic [31:0] cause;
    logic [31:0] epc;
    bit          found;
    isSync  = (inst == ECALL) || (inst == EBREAK);
    isMret  = !isSync && (inst == MRET);
    isAsync = !isSync && !isMret && (intFlag != 8'h0) && mie;
    found   = 0;
    cause   = 32'h0;
    for (int b = 0; b < 8; b++) begin
      if (!found && intFlag[b]) begin
        cause = 32'h8000_0010 + b;
        found = 1;
      end
    end
    if (inst == ECALL) cause = 32'd11;
    if (inst == EBREAK) cause = 32'd3;
    epc = (isAsync && jf) ? ja : addr;

    expQ.delete();
    expQ.push_back(mkCycle(isSync || isMret || isAsync, 0, 0, 0, 0, 0, 0));
    if (isAsync) begin
      for (int w = 0; w < divWait; w++) expQ.push_back(mkCycle(1, 0, 0, 0, 0, 0, 0));
    end
    if (isSync || isAsync) begin
      expQ.push_back(mkCycle(1, 1, 32'h341, 0, epc, 0, 0));
      expQ.push_back(mkCycle(1, 1, 32'h300, 1, 0, 0, 0));
      expQ.push_back(mkCycle(1, 1, 32'h342, 0, cause, 0, 0));
      expQ.push_back(mkCycle(1, 0, 0, 0, 0, 1, 1));
    end else if (isMret) begin
      expQ.push_back(mkCycle(1, 1, 32'h300, 2, 0, 0, 0));
      expQ.push_back(mkCycle(1, 0, 0, 0, 0, 1, 2));
    end

    for (int i = 0; i < expQ.size(); i++) begin
      if (i == 0) begin
        inst_i = inst; inst_addr_i = addr; int_flag_i = intFlag;
        global_int_en_i = mie; jump_flag_i = jf; jump_addr_i = ja;
        div_started_i = isAsync ? (divWait > 0) : 1'($urandom);
        driveCsr();
      end else begin
        driveNoise();
        if (isAsync && i <= divWait) div_started_i = (i < divWait);
        else div_started_i = 1'($urandom);
      end
      @(negedge clk);
      checkCycle(expQ[i], $sformatf("%s.c%0d", tag, i));
      @(posedge clk);
      #1;
    end
  endtask

  // Reset asserted while the mstatus write is on the port
  task automatic resetMidSequence();
    driveQuiet();
    inst_i = ECALL; inst_addr_i = 32'h300;
    @(negedge clk);
    checkOutput("rstmid.detect.hold", hold_flag_o, 1'b1);
    @(posedge clk); #1;
    driveQuiet();
    @(negedge clk);
    checkOutput("rstmid.mepc.data", data_o, 32'h300);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstmid.mstatus.we", we_o, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstmid.after.hold", hold_flag_o, 1'b0);
    checkOutput("rstmid.after.we", we_o, 1'b0);
    checkOutput("rstmid.after.waddr", waddr_o, 32'h0);
    checkOutput("rstmid.after.data", data_o, 32'h0);
    checkOutput("rstmid.after.assert", int_assert_o, 1'b0);
    checkOutput("rstmid.after.int_addr", int_addr_o, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rstmid.idle.assert", int_assert_o, 1'b0);
    checkOutput("rstmid.idle.we", we_o, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rInst;
    logic [7:0]  rInt;
    int          rWait;

    rst = 1'b1;
    driveQuiet();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("reset.hold", hold_flag_o, 1'b0);
    checkOutput("reset.we", we_o, 1'b0);
    checkOutput("reset.waddr", waddr_o, 32'h0);
    checkOutput("reset.data", data_o, 32'h0);
    checkOutput("reset.assert", int_assert_o, 1'b0);
    checkOutput("reset.int_addr", int_addr_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ecall trap entry
    msBase = 32'h8; mtvecBase = 32'h400; mepcBase = 32'h0;
    applyStimulus(ECALL, 32'h100, 8'h0, 0, 0, 32'h0, 0, "ecall");
    // mret
    msBase = 32'h80; mepcBase = 32'h104;
    applyStimulus(MRET, 32'h180, 8'h0, 0, 0, 32'h0, 0, "mret");
    // masked interrupt, then enabled
    msBase = 32'h8;
    applyStimulus(NOP, 32'h110, 8'h04, 0, 0, 32'h0, 0, "intmasked");
    applyStimulus(NOP, 32'h110, 8'h04, 1, 0, 32'h0, 0, "intenabled");
    // interrupt waiting on the divider, redirect target saved
    applyStimulus(NOP, 32'h120, 8'h01, 1, 1, 32'h200, 5, "divwait");
    // ecall beats a simultaneous interrupt; interrupt taken afterwards
    applyStimulus(ECALL, 32'h130, 8'h01, 1, 0, 32'h0, 0, "ecallint");
    applyStimulus(NOP, 32'h134, 8'h01, 1, 0, 32'h0, 0, "intlater");
    // ebreak
    applyStimulus(EBREAK, 32'h140, 8'h80, 1, 1, 32'h240, 0, "ebreak");

    resetMidSequence();

    randomCsr = 1;
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 5))
        0:       rInst = ECALL;
        1:       rInst = EBREAK;
        2:       rInst = MRET;
        default: begin
          rInst = $urandom;
          if (rInst == ECALL || rInst == EBREAK || rInst == MRET) rInst = NOP;
        end
      endcase
      if ($urandom_range(0, 1) == 0) rInt = 8'h0;
      else if ($urandom_range(0, 1) == 0) rInt = 8'h1 << $urandom_range(0, 7);
      else rInt = 8'($urandom);
      rWait = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
      applyStimulus(rInst, $urandom, rInt, 1'($urandom), 1'($urandom), $urandom, rWait,
                    $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
